// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streaming block.
package fifo_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int IDX_W     = 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

  function automatic logic [1:0] state_entries(input buf_state_t s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry circular data store for the stream output; head entry drives rd_data.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                rd_en,
  output logic [DATA_LEN-1:0] rd_data
);

  logic [IDX_W-1:0]    head_reg;
  logic [IDX_W-1:0]    tail_reg;
  logic [DATA_LEN-1:0] entries [BUF_DEPTH];

  always_ff @(posedge rclk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (wr_en) tail_reg <= tail_reg + 1'b1;
      if (rd_en) head_reg <= head_reg + 1'b1;
    end
  end

  // Entries are cleared on reset so the stream output reads zero while idle.
  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [DATA_LEN-1:0] entry_reg;

      always_ff @(posedge rclk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en && (tail_reg == IDX_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = entries[head_reg];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Optional rd_count output enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic [DATA_LEN-1:0] fifo_rdata,
  output logic                fifo_read_en,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_LEN-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]         rd_count
`endif
);

  buf_state_t state_reg;
  buf_state_t state_next;
  logic       inflight_reg;
  logic       pop;
  logic [1:0] occ;

  assign m_valid = (state_reg != S_EMPTY);
  assign pop     = m_valid & m_ready;

  // A read in flight already owns a buffer slot, so it counts toward occupancy.
  assign occ          = state_entries(state_reg) + {1'b0, inflight_reg};
  assign fifo_read_en = !fifo_empty && !rst && ((occ < 2'(BUF_DEPTH)) || pop);

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_reg    <= S_EMPTY;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_read_en;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY: if (inflight_reg) state_next = S_ONE;
      S_ONE: begin
        if (inflight_reg && !pop)      state_next = S_TWO;
        else if (pop && !inflight_reg) state_next = S_EMPTY;
      end
      S_TWO:   if (pop && !inflight_reg) state_next = S_ONE;
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rst) begin
      assert (!(inflight_reg && (state_reg == S_TWO) && !pop));
    end
  end

  fifo_skid_buf #(
    .DATA_LEN (DATA_LEN)
  ) u_skid_buf (
    .rclk    (rclk),
    .rst     (rst),
    .wr_en   (inflight_reg),
    .wr_data (fifo_rdata),
    .rd_en   (pop),
    .rd_data (m_data)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] rd_count_reg;

  always_ff @(posedge rclk) begin
    if (rst) begin
      rd_count_reg <= '0;
    end else if (pop) begin
      rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign rd_count = rd_count_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-backed FIFO model feeds the read port,
// words are queued as expected when read and compared in order when popped.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DATA_LEN = 32;

  logic                rclk       = 1'b0;
  logic                rst        = 1'b1;
  logic                fifo_empty = 1'b1;
  logic [DATA_LEN-1:0] fifo_rdata = '0;
  logic                m_ready    = 1'b0;
  logic                fifo_read_en;
  logic                m_valid;
  logic [DATA_LEN-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]         rd_count;
`endif

  fifo_rd_stream #(.DATA_LEN(DATA_LEN)) dut (
    .rclk         (rclk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_read_en (fifo_read_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .rd_count     (rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads = 0;
  int pops = 0;
  int exp_cnt = 0;
  int first_rd_cyc = -1;
  int first_valid_cyc = -1;
  int burst_first = -1;
  int last_pop_cyc = -1;
  bit verbose = 1'b1;
  bit prev_valid = 1'b0;
  bit prev_pop = 1'b0;
  bit prev_rst = 1'b1;
  logic [DATA_LEN-1:0] prev_data = '0;
  logic [DATA_LEN-1:0] fifo_q[$];
  logic [DATA_LEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [DATA_LEN-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at the falling edge, then update the FIFO model just after the rising edge.
  task automatic cycle();
    logic rd_s, pop_s, rst_s;
    logic [DATA_LEN-1:0] w;
    w = '0;
    @(negedge rclk);
    rd_s  = fifo_read_en;
    pop_s = m_valid && m_ready;
    rst_s = rst;
    if (rst_s) check("rst_rd_en", {31'b0, fifo_read_en}, 32'd0);
    if (prev_rst) begin
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      check("rst_data", m_data, 32'd0);
    end else if (prev_valid && !prev_pop) begin
      check("hold_valid", {31'b0, m_valid}, 32'd1);
      check("hold_data", m_data, prev_data);
    end
    check("rd_when_empty", {31'b0, rd_s & fifo_empty}, 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("rd_count", {16'b0, rd_count}, exp_cnt & 32'hFFFF);
`endif
    if (rd_s && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      reads++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pop_s) begin
      if (exp_q.size() == 0) check("unexpected_pop", m_data, 32'hxxxx_xxxx);
      else check("pop_data", m_data, exp_q.pop_front());
      if (verbose) $display("pop cycle=%0d data=%h", cyc, m_data);
      pops++;
      exp_cnt++;
      if (burst_first < 0) burst_first = cyc;
      last_pop_cyc = cyc;
    end
    prev_valid = m_valid;
    prev_pop   = pop_s;
    prev_data  = m_data;
    prev_rst   = rst_s;
    @(posedge rclk);
    #1;
    cyc++;
    if (rst_s) begin
      exp_q.delete();
      exp_cnt = 0;
    end
    fifo_rdata = rd_s ? w : $urandom();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_pops(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pops < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, {31'b0, pops >= target}, 32'd1);
  endtask

  task automatic mark();
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    burst_first     = -1;
  endtask

  initial begin
    int p0, r0;

    // Reset gating: a non-empty FIFO must not be read while rst is high.
    push_word(32'hDEAD_BEEF);
    repeat (3) cycle();
    fifo_q.delete();
    fifo_empty = 1'b1;
    rst = 1'b0;

    // Empty FIFO stays idle.
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_rd_en", {31'b0, fifo_read_en}, 32'd0);
      check("idle_valid", {31'b0, m_valid}, 32'd0);
    end

    // Single word latency.
    mark();
    m_ready = 1'b1;
    p0 = pops;
    push_word(32'hA5A5_A5A5);
    run_until_pops(p0 + 1, 20, "single_timeout");
    check("single_latency", first_valid_cyc - first_rd_cyc, 32'd2);
    repeat (4) cycle();
    check("single_once", pops - p0, 32'd1);

    // Eight words streamed back-to-back.
    mark();
    p0 = pops;
    for (int i = 1; i <= 8; i++) push_word(32'(i));
    run_until_pops(p0 + 8, 40, "burst_timeout");
    check("burst_latency", burst_first - first_rd_cyc, 32'd2);
    check("burst_rate", last_pop_cyc - burst_first, 32'd7);

    // Backpressure: only two reads, buffer full, head held.
    m_ready = 1'b0;
    repeat (3) cycle();
    r0 = reads;
    p0 = pops;
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    repeat (6) cycle();
    check("bp_reads", reads - r0, 32'd2);
    check("bp_state", 32'(dut.state_reg), 32'(S_TWO));
    check("bp_valid", {31'b0, m_valid}, 32'd1);
    check("bp_head", m_data, 32'd1);
    m_ready = 1'b1;
    run_until_pops(p0 + 4, 30, "bp_drain_timeout");

    // Random backpressure with a mixed FIFO.
    p0 = pops;
    for (int i = 0; i < 30; i++) push_word($urandom());
    for (int i = 0; i < 400 && pops < p0 + 30; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    m_ready = 1'b1;
    run_until_pops(p0 + 30, 40, "rand_timeout");

    // Reset with a read in flight: the returned word must be dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h100 + 32'(i));
    repeat (4) cycle();
    check("rst_pre_state", 32'(dut.state_reg), 32'(S_TWO));
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    check("rst_pre_inflight", {31'b0, dut.inflight_reg}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_valid", {31'b0, m_valid}, 32'd0);
    end
    check("post_rst_no_pop", pops - p0, 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap after 65536 pops.
    verbose = 1'b0;
    p0 = pops;
    for (int i = 0; i < 65536; i++) push_word(32'(i));
    run_until_pops(p0 + 65535, 66000, "wrap_pre_timeout");
    m_ready = 1'b0;
    cycle();
    check("wrap_pre", {16'b0, rd_count}, 32'h0000_FFFF);
    m_ready = 1'b1;
    run_until_pops(p0 + 65536, 20, "wrap_timeout");
    m_ready = 1'b0;
    cycle();
    check("wrap_zero", {16'b0, rd_count}, 32'h0000_0000);
    verbose = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
